// File: rtl/ft_recovery_seq.sv
// ft_recovery_seq: lockstep recovery sequencer that restores GPRs and NPC in both cores over the debug port.
// Optional FT_RECOVERY_CNT_EN adds a saturating recovery_count_o.
module ft_recovery_seq #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        commit_we_i,
  input  logic [4:0]  commit_addr_i,
  input  logic [31:0] commit_data_i,
  input  logic [31:0] commit_pc_i,
  input  logic        error_i,
  input  logic [1:0]  debug_halted_i,
  input  logic [1:0]  debug_gnt_i,
  output logic [1:0]  debug_req_o,
  output logic        debug_we_o,
  output logic [14:0] debug_addr_o,
  output logic [31:0] debug_wdata_o,
  output logic        halt_o,
  output logic        resume_o,
  output logic        busy_o,
  output logic        fatal_o
`ifdef FT_RECOVERY_CNT_EN
  ,
  output logic [7:0]  recovery_count_o
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HALT, WR_GPR, WR_PC, RESUME, FAIL} state_t;
  state_t state_q, state_d;
  logic [31:0] shadow_q [32];
  logic [31:0] pc_q, pc_d;
  logic [4:0] idx_q, idx_d;
  logic [1:0] halted_q, halted_d, done_q, done_d, done_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, commit;
  always_comb begin
    commit = state_q == IDLE && commit_we_i && commit_addr_i != 5'd0 && !error_i;
    wr = state_q == WR_GPR || state_q == WR_PC;
    debug_req_o = wr ? ~done_q : 2'b00;
    done_nx = done_q | (debug_gnt_i & debug_req_o);
    debug_we_o = |debug_req_o;
    debug_addr_o = !debug_we_o ? 15'd0 : state_q == WR_PC ? 15'h2000 : 15'h0400 + {8'd0, idx_q, 2'b00};
    debug_wdata_o = !debug_we_o ? 32'd0 : state_q == WR_PC ? pc_q : shadow_q[idx_q];
    halt_o = state_q inside {HALT, WR_GPR, WR_PC, FAIL};
    resume_o = state_q == RESUME;
    busy_o = state_q != IDLE;
    fatal_o = state_q == FAIL;
    pc_d = commit ? commit_pc_i : pc_q;
    state_d = state_q;
    idx_d = idx_q;
    halted_d = halted_q;
    done_d = done_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (error_i) begin
        state_d = HALT;
        cnt_d = '0;
        halted_d = 2'b00;
      end
      HALT: begin
        halted_d = halted_q | debug_halted_i;
        cnt_d = cnt_q + CW'(1);
        if (&halted_q) begin
          state_d = WR_GPR;
          idx_d = 5'd1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) state_d = FAIL;
      end
      WR_GPR, WR_PC: begin
        // a write retires only once both cores have granted it
        done_d = &done_nx ? 2'b00 : done_nx;
        if (&done_nx) begin
          idx_d = idx_q + 5'd1;
          state_d = state_q == WR_PC ? RESUME : idx_q == 5'd31 ? WR_PC : WR_GPR;
        end
      end
      RESUME: state_d = IDLE;
      default: ;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q <= '0;
      idx_q <= '0;
      halted_q <= '0;
      done_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      idx_q <= idx_d;
      halted_q <= halted_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
      if (commit) shadow_q[commit_addr_i] <= commit_data_i;
    end
  end
`ifdef FT_RECOVERY_CNT_EN
  logic [7:0] count_q, count_d;
  always_comb count_d = resume_o && count_q != 8'hFF ? count_q + 8'd1 : count_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else count_q <= count_d;
  end
  assign recovery_count_o = count_q;
`endif
endmodule

// File: tb/tb_ft_recovery_seq.sv
// tb_ft_recovery_seq: directed bench for ft_recovery_seq with hand-computed shadow contents.
module tb_ft_recovery_seq;
  logic clk = 0, rst_i = 1;
  logic commit_we_i = 0, error_i = 0;
  logic [4:0] commit_addr_i = 0;
  logic [31:0] commit_data_i = 0, commit_pc_i = 0;
  logic [1:0] debug_halted_i = 0, debug_gnt_i, debug_req_o;
  logic debug_we_o, halt_o, resume_o, busy_o, fatal_o;
  logic [14:0] debug_addr_o;
  logic [31:0] debug_wdata_o;
`ifdef FT_RECOVERY_CNT_EN
  logic [7:0] recovery_count;
`endif
  int n_chk = 0, n_fail = 0;
  logic slow1 = 0;
  int c1 = 0;
  logic [31:0] exp_sh [32];
  logic [31:0] exp_pc;

  ft_recovery_seq dut (
    .clk_i(clk), .rst_i(rst_i),
    .commit_we_i(commit_we_i), .commit_addr_i(commit_addr_i),
    .commit_data_i(commit_data_i), .commit_pc_i(commit_pc_i),
    .error_i(error_i), .debug_halted_i(debug_halted_i), .debug_gnt_i(debug_gnt_i),
    .debug_req_o(debug_req_o), .debug_we_o(debug_we_o), .debug_addr_o(debug_addr_o),
    .debug_wdata_o(debug_wdata_o), .halt_o(halt_o), .resume_o(resume_o),
    .busy_o(busy_o), .fatal_o(fatal_o)
`ifdef FT_RECOVERY_CNT_EN
    , .recovery_count_o(recovery_count)
`endif
  );

  always #5 clk = ~clk;
  // core 0 grants at once; core 1 optionally grants 3 cycles later
  assign debug_gnt_i = {slow1 ? (debug_req_o[1] && c1 == 3) : debug_req_o[1], debug_req_o[0]};
  always_ff @(posedge clk) c1 <= (debug_req_o[1] && !debug_gnt_i[1]) ? c1 + 1 : 0;

  typedef struct {
    logic we; logic [4:0] a; logic [31:0] d; logic [31:0] pc;
    logic [4:0] ei; logic [31:0] ev;
  } vec_t;
  vec_t vecs[5];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(debug_req_o), 0);
    chk({tag, "_we"}, 32'(debug_we_o), 0);
    chk({tag, "_addr"}, 32'(debug_addr_o), 0);
    chk({tag, "_wdata"}, debug_wdata_o, 0);
    chk({tag, "_halt"}, 32'(halt_o), 0);
    chk({tag, "_resume"}, 32'(resume_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_fatal"}, 32'(fatal_o), 0);
  endtask

  task automatic recover(input logic slow, input int lat_exp, input int abort_cur, input logic noise);
    int wn[2];
    int cur;
    logic [14:0] ea;
    logic [31:0] ed;
    logic done;
    slow1 = slow;
    error_i = 1;
    if (noise) begin
      commit_we_i = 1; commit_addr_i = 5'd7; commit_data_i = 32'hAA; commit_pc_i = 32'h999;
    end
    step;
    error_i = 0;
    commit_we_i = 0;
    chk("halt_t1", 32'(halt_o), 1);
    chk("busy_t1", 32'(busy_o), 1);
    step;
    debug_halted_i = 2'b11;
    step;
    wn = '{0, 0};
    done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      cur = wn[0] < wn[1] ? wn[0] : wn[1];
      if (resume_o) begin
        chk("resume_latency", n, lat_exp);
        chk("writes_done", cur, 32);
        chk("resume_halt", 32'(halt_o), 0);
        done = 1;
      end else if (debug_req_o != 2'b00) begin
        ea = cur == 31 ? 15'h2000 : 15'h0400 + 15'(4 * (cur + 1));
        ed = cur == 31 ? exp_pc : exp_sh[cur + 1];
        chk("wr_addr", 32'(debug_addr_o), 32'(ea));
        chk("wr_data", debug_wdata_o, ed);
        chk("wr_we", 32'(debug_we_o), 1);
        chk("wr_req", 32'(debug_req_o), 32'({wn[1] == cur, wn[0] == cur}));
        for (int k = 0; k < 2; k++) if (debug_req_o[k] && debug_gnt_i[k]) wn[k]++;
      end
      if (!done) begin
        if (abort_cur == cur && debug_req_o != 2'b00) begin
          rst_i = 1;
          step;
          rst_i = 0;
          debug_halted_i = 0;
          chk_zero("abort");
          return;
        end
        if (noise) begin
          commit_we_i = 1; commit_addr_i = 5'd5; commit_data_i = 32'hDEADBEEF; commit_pc_i = 32'h444;
          error_i = n == 5;
        end
        step;
      end
    end
    if (!done) chk("resume_timeout", 0, 1);
    debug_halted_i = 0;
    commit_we_i = 0;
    error_i = 0;
    step;
    chk("post_busy", 32'(busy_o), 0);
    chk("post_resume", 32'(resume_o), 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd31, 32'hCAFEF00D, 32'h7C, 5'd31, 32'hCAFEF00D};
    vecs[1] = '{1'b1, 5'd5, 32'h12345678, 32'h80, 5'd5, 32'h12345678};
    vecs[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h84, 5'd0, 32'h0};
    vecs[3] = '{1'b0, 5'd3, 32'h33333333, 32'h90, 5'd0, 32'h0};
    vecs[4] = '{1'b1, 5'd7, 32'h00000077, 32'h80, 5'd7, 32'h77};
    for (int i = 0; i < 32; i++) exp_sh[i] = 0;
    exp_pc = 32'h80;
    step;
    step;
    rst_i = 0;
    chk_zero("reset");
`ifdef FT_RECOVERY_CNT_EN
    chk("cnt_reset", 32'(recovery_count), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      commit_we_i = vecs[i].we; commit_addr_i = vecs[i].a;
      commit_data_i = vecs[i].d; commit_pc_i = vecs[i].pc;
      step;
      chk("commit_busy", 32'(busy_o), 0);
      chk("commit_req", 32'(debug_req_o), 0);
      if (vecs[i].ei != 0) exp_sh[vecs[i].ei] = vecs[i].ev;
    end
    commit_we_i = 0;
    step;
    recover(0, 33, -1, 0);
    recover(1, 129, -1, 0);
    recover(0, 33, -1, 1);
    for (int i = 0; i < 40; i++) begin
      step;
      chk("single_resume", 32'(resume_o), 0);
      chk("single_busy", 32'(busy_o), 0);
    end
`ifdef FT_RECOVERY_CNT_EN
    chk("cnt_three", 32'(recovery_count), 3);
`endif
    recover(0, 33, 9, 0);
`ifdef FT_RECOVERY_CNT_EN
    chk("cnt_abort", 32'(recovery_count), 0);
`endif
    for (int i = 0; i < 32; i++) exp_sh[i] = 0;
    exp_pc = 0;
    step;
    recover(0, 33, -1, 0);
`ifdef FT_RECOVERY_CNT_EN
    chk("cnt_one", 32'(recovery_count), 1);
`endif
    error_i = 1;
    step;
    error_i = 0;
    for (int i = 1; i <= 74; i++) begin
      step;
      chk("to_fatal", 32'(fatal_o), 32'(i >= 64));
      chk("to_halt", 32'(halt_o), 1);
      chk("to_req", 32'(debug_req_o), 0);
    end
    rst_i = 1;
    step;
    rst_i = 0;
    chk_zero("fail_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ft_recovery_seq.md
# ft_recovery_seq

Debug-port recovery sequencer for the lockstep dual-core FT system. It sits between the fault-tolerance comparator and the two cores' debug interfaces. It keeps a shadow register file and PC built from validated (matching) commits. On a mismatch it halts both cores, rewrites all 31 GPRs and the NPC in both cores through proper req/gnt debug transactions, then resumes them.

## Interface
Parameters:
- TIMEOUT, default 64: max cycles to wait for both cores to report halted before declaring a fatal error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- commit_we_i  in  1  validated register-file write from comparator.
- commit_addr_i  in  5  GPR index of validated write.
- commit_data_i  in  32  data of validated write.
- commit_pc_i  in  32  PC of last validated instruction; captured as checkpoint PC.
- error_i  in  1  mismatch pulse from comparator.
- debug_halted_i  in  2  per-core debug_halted (bit0 core 0, bit1 core 1).
- debug_gnt_i  in  2  per-core debug grant.
- debug_req_o  out  2  per-core debug request.
- debug_we_o  out  1  debug write enable, shared by both cores.
- debug_addr_o  out  15  debug address, shared.
- debug_wdata_o  out  32  debug write data, shared.
- halt_o  out  1  halt request to both cores.
- resume_o  out  1  resume pulse to both cores.
- busy_o  out  1  recovery in progress.
- fatal_o  out  1  sticky halt-timeout error.

## Operation
- Shadow file: 32x32 array plus 32-bit checkpoint PC, both cleared to 0 on reset.
  - In IDLE, when commit_we_i=1 and commit_addr_i!=0, shadow[addr] is set to data and checkpoint PC to commit_pc_i.
  - Shadow[0] always reads 0.
  - A commit in the same cycle as error_i is discarded (treated as suspect).
  - Commits in any non-IDLE state are ignored.
- FSM states: IDLE, HALT, WR_GPR, WR_PC, RESUME, FAIL.
  - IDLE: on error_i, go to HALT and clear the timeout counter.
  - HALT: halt_o=1. A per-core sticky halted flag is set from debug_halted_i. When both flags are set, go to WR_GPR with idx=1. If the counter reaches TIMEOUT first, go to FAIL.
  - WR_GPR: debug_we_o=1, debug_addr_o=15'h0400+4*idx, debug_wdata_o=shadow[idx].
    - debug_req_o[k] is held high until debug_gnt_i[k] is sampled with req; core k's done flag is then set and its req drops.
    - When both done flags are set, clear them and increment idx. After idx=31, go to WR_PC.
  - WR_PC: same handshake with debug_addr_o=15'h2000 (NPC) and debug_wdata_o=checkpoint PC. When both cores are done, go to RESUME.
  - RESUME: one cycle with resume_o=1 and halt_o=0, then IDLE.
  - FAIL: fatal_o=1 and halt_o=1, held until reset. No debug traffic.
- error_i outside IDLE is ignored.
- debug_addr_o, debug_wdata_o and debug_we_o are 0 when debug_req_o==0.
- busy_o=1 in every state except IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, shadow and PC 0, sticky flags clear.
- Reset asserted mid-recovery aborts immediately. Next cycle all outputs are 0.
- error_i at cycle T gives halt_o=1 and busy_o=1 at T+1.
- The HALT->WR_GPR transition occurs the cycle after both sticky halted flags are set.
- With zero-wait grants, each write takes 1 cycle: 31 GPR writes plus 1 PC write is 32 cycles, then 1 RESUME cycle.
- Total latency from first both-halted cycle to resume_o is 33 cycles.
- Grants may arrive on different cycles per core. A write advances only once both cores have granted it, never earlier.
- All outputs are registered except the debug_req_o gating, which uses the registered done flags.

## Configuration
- FT_RECOVERY_CNT_EN defined:
  - Adds output recovery_count_o [7:0], reset to 0.
  - Increments on each RESUME cycle and saturates at 8'hFF.
- Not defined: the port is absent and no counter logic exists.

## Test plan
- Reset, then commits r5=0x12345678 (pc 0x80) and r0=0xFFFFFFFF, then error_i. Both cores halt on cycle +2 with zero-wait gnt. Required: writes to 0x0414 carry 0x12345678, write to 0x0400 is absent (idx starts at 1), write to 0x2000 carries 0x80, and resume_o pulses exactly 33 cycles after halt is seen.
- Core 1 grants 3 cycles after core 0 on every write. Required: debug_req_o[0] drops after its gnt, and idx does not advance until debug_gnt_i[1] arrives.
- debug_halted_i never asserts. Required: fatal_o=1 and state FAIL at T+1+TIMEOUT, halt_o stays 1, and no debug_req_o activity.
- commit_we_i with r7=0xAA in the same cycle as error_i, and a second error_i during WR_GPR. Required: shadow r7 keeps its old value, and exactly one RESUME occurs.
- rst_i asserted during WR_GPR idx=10. Required: the next cycle has all outputs 0; a following error_i restores zeros (shadow cleared). With FT_RECOVERY_CNT_EN, the count reads 0 after reset and 1 after the next completed recovery.
